tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//  Receive end of the 4:1 channel mux: takes a time-division-multiplexed beat stream
//  (one beat per slot, slot 0 marked by in_sof) and distributes beats to NCH channel outputs.
//  Beats of a frame are collected in shadow registers; all channels update together
//  when the frame completes. Tracks frame alignment (HUNT/LOCKED) and flags sync errors.
// PARAMETERS
//  WIDTH  1  data bits per slot/channel
//  NCH    4  channels (slots) per frame, >=2; SEL_W = $clog2(NCH)
// PORTS
//  clk        in   1          single clock, all logic on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   1          beat present on in_data this cycle
//  in_data    in   WIDTH      slot payload
//  in_sof     in   1          start-of-frame; qualifies in_valid beat as slot 0
//  ch_data    out  NCH*WIDTH  committed frame; channel k at [k*WIDTH +: WIDTH]
//  out_valid  out  1          1-cycle pulse: ch_data updated with a complete frame
//  locked     out  1          1 = aligned to frame (state LOCKED)
//  slot       out  SEL_W      slot index the next valid beat will fill
//  sync_err   out  1          1-cycle pulse: alignment fault detected
// BEHAVIOUR
//  - Reset (async, rst_n=0): state HUNT; ch_data, shadow, slot, out_valid, locked, sync_err = 0.
//  - in_valid=0: no state change; outputs hold, pulses deassert.
//  - HUNT: beats without in_sof discarded. in_valid&in_sof -> beat stored shadow[0],
//    slot<=1, state LOCKED.
//  - LOCKED, in_valid=1, slot=s:
//     s!=0, in_sof=0: shadow[s]<=in_data; slot<=s+1 (wraps NCH-1 -> 0).
//     s==NCH-1 (no sof): also commit: ch_data<=shadow with slot NCH-1 = in_data,
//       out_valid=1 next cycle. Latency: last beat at cycle N -> ch_data/out_valid at N+1.
//     s!=0, in_sof=1 (early sof): sync_err pulse; partial frame discarded (no commit);
//       beat taken as slot 0 -> shadow[0], slot<=1, stay LOCKED.
//     s==0, in_sof=1: normal frame start, shadow[0]<=in_data, slot<=1.
//     s==0, in_sof=0 (missing sof): sync_err pulse; beat discarded; state HUNT, slot<=0.
//  - out_valid and sync_err never assert in the same cycle; both are registered.
//  - ch_data changes only on commit; holds between frames and through HUNT.
//  - Shadow entries not rewritten are never committed (commit only after slots 0..NCH-1
//    all written in the current frame).
//  - Reset asserted mid-frame: partial frame lost, ch_data cleared to 0.
//  - locked = (state==LOCKED); slot output = internal counter (0 while HUNT).
// STRUCTURE
//  - Package tdm_pkg: typedef enum logic {HUNT, LOCKED} tdm_state_t; NCH_DEFAULT=4.
//  - Sub-module tdm_slot_counter (SEL_W-bit counter: clear, load-1, inc with wrap,
//    wrap flag) instantiated once; state FSM, shadow array and commit regs in top.
// TESTING (WIDTH=1, NCH=4, one beat per cycle unless stated)
//  1 Reset then frames {sof,1},{0},{0},{0} and {sof,0},{0},{0},{1} -> ch_data=4'b0001 then
//    4'b1000, one out_valid per frame, locked=1 after first beat, sync_err never.
//  2 Beats 1,1 without sof then sof frame 0,1,0,0 -> first two discarded (locked=0),
//    ch_data=4'b0010 one cycle after 4th beat of frame.
//  3 Early sof: sof,1,1 then sof,0,0,1,0 -> sync_err pulse on 2nd sof, no commit of
//    partial frame, next commit ch_data=4'b0100.
//  4 Missing sof at slot 0 after good frame -> sync_err pulse, locked=0, slot=0,
//    ch_data holds previous frame value.
//  5 Gaps: in_valid toggled 1/0 through a frame 1,0,1,1 -> ch_data=4'b1101, out_valid
//    once; outputs stable during in_valid=0 cycles.
//  6 Assert rst_n=0 after slot 2 of a frame -> all outputs 0 immediately (async),
//    HUNT after release, no out_valid.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive path.
// Frame alignment states and the default channel count.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    localparam int NCH_DEFAULT = 4;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demux: clear, load-1, increment with wrap.
// wrap is high while the counter sits on the last slot of the frame.
module tdm_slot_counter #(
    parameter int NCH   = 4,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NCH - 1);
    localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

    assign wrap = (cnt == LAST);

    // clr wins over load1, load1 over inc; NCH need not be a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= ONE;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the TDM channel mux: collects one beat per slot into a shadow
// frame, commits all channels at once, and tracks frame alignment.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int NCH   = NCH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sof,
    output logic [NCH*WIDTH-1:0]     ch_data,
    output logic                     out_valid,
    output logic                     locked,
    output logic [$clog2(NCH)-1:0]   slot,
    output logic                     sync_err
);

    localparam int SEL_W = $clog2(NCH);

    tdm_state_t              state;
    tdm_state_t              next_state;
    logic [NCH*WIDTH-1:0]    shadow;
    logic [NCH*WIDTH-1:0]    frame;
    logic [SEL_W-1:0]        cnt;
    logic                    cnt_wrap;
    logic                    cnt_clr;
    logic                    take_sof;
    logic                    take_mid;
    logic                    commit;
    logic                    err;
    logic                    at_slot0;

    assign at_slot0 = (cnt == '0);

    tdm_slot_counter #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load1 (take_sof),
        .inc   (take_mid),
        .cnt   (cnt),
        .wrap  (cnt_wrap)
    );

    // Beat decode: every accepted beat is either a frame start or a mid-frame slot
    always_comb begin
        next_state = state;
        take_sof   = 1'b0;
        take_mid   = 1'b0;
        commit     = 1'b0;
        err        = 1'b0;
        cnt_clr    = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_sof) begin
                        take_sof   = 1'b1;
                        next_state = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sof) begin
                        take_sof = 1'b1;
                        err      = !at_slot0;
                    end else if (at_slot0) begin
                        err        = 1'b1;
                        cnt_clr    = 1'b1;
                        next_state = HUNT;
                    end else begin
                        take_mid = 1'b1;
                        commit   = cnt_wrap;
                    end
                end
                default: next_state = HUNT;
            endcase
        end
    end

    // The last slot bypasses the shadow so the commit lands one cycle after it
    always_comb begin
        frame                              = shadow;
        frame[(NCH-1)*WIDTH +: WIDTH]      = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            shadow    <= '0;
            ch_data   <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= next_state;
            out_valid <= commit;
            sync_err  <= err;
            if (take_sof) begin
                shadow[0 +: WIDTH] <= in_data;
            end
            if (take_mid) begin
                shadow[int'(cnt)*WIDTH +: WIDTH] <= in_data;
            end
            if (commit) begin
                ch_data <= frame;
            end
        end
    end

    assign locked = (state == LOCKED);
    assign slot   = cnt;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed frame scenarios plus random beats
// against a queue-based frame model.
module tb_tdm_demux4;

    localparam int WIDTH = 1;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    localparam int VW    = NCH*WIDTH + 4 + SEL_W - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 in_sof = 1'b0;
    logic [NCH*WIDTH-1:0] ch_data;
    logic                 out_valid;
    logic                 locked;
    logic [SEL_W-1:0]     slot;
    logic                 sync_err;

    int tests_run = 0;
    int failures  = 0;

    tdm_demux4 #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .ch_data   (ch_data),
        .out_valid (out_valid),
        .locked    (locked),
        .slot      (slot),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: the beats gathered so far in the current frame
    logic             m_q[$];
    logic             m_locked;
    logic [NCH-1:0]   m_ch;
    logic             m_ov;
    logic             m_err;

    task automatic model_reset();
        m_q.delete();
        m_locked = 1'b0;
        m_ch     = '0;
        m_ov     = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_beat(input logic v, input logic s, input logic d);
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_q.delete();
                    m_q.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (s) begin
                if (m_q.size() != 0) m_err = 1'b1;
                m_q.delete();
                m_q.push_back(d);
            end else if (m_q.size() == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == NCH) begin
                    for (int k = 0; k < NCH; k++) m_ch[k] = m_q[k];
                    m_ov = 1'b1;
                    m_q.delete();
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {m_ch, m_ov, m_locked, SEL_W'(m_q.size()), m_err};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {ch_data, out_valid, locked, slot, sync_err};
    endfunction

    // Drive one cycle of input, let the DUT clock it, sample 1 time unit later
    task automatic step(input logic v, input logic s, input logic d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        model_beat(v, s, d);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b want=%b", obs_vec(), {VW{1'b0}});
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        rst_n    = 1'b1;
    endtask

    task automatic test_frames();
        logic [2:0] pat [8] = '{3'b111, 3'b100, 3'b100, 3'b100,
                                3'b110, 3'b100, 3'b100, 3'b101};
        int ov_cnt = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            if (out_valid) ov_cnt++;
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL frames_beat%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (i == 0) begin
                tests_run++;
                if (locked !== 1'b1) begin
                    failures++;
                    $display("FAIL frames_locked got=%b want=1", locked);
                end
            end
            if (i == 3 || i == 7) begin
                tests_run++;
                if (ch_data !== (i == 3 ? 4'b0001 : 4'b1000) || out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL frames_commit%0d got=%b/%b want=%b/1", i, ch_data,
                             out_valid, (i == 3 ? 4'b0001 : 4'b1000));
                end
            end
            if (sync_err !== 1'b0) begin
                tests_run++;
                failures++;
                $display("FAIL frames_sync_err beat%0d got=1 want=0", i);
            end
        end
        tests_run++;
        if (ov_cnt != 2) begin
            failures++;
            $display("FAIL frames_ov_count got=%0d want=2", ov_cnt);
        end
    endtask

    task automatic test_hunt_discard();
        logic [2:0] pat [6] = '{3'b101, 3'b101, 3'b110, 3'b101, 3'b100, 3'b100};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hunt_beat%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (i < 2) begin
                tests_run++;
                if (locked !== 1'b0 || slot !== 2'd0) begin
                    failures++;
                    $display("FAIL hunt_discard%0d got=%b/%0d want=0/0", i, locked, slot);
                end
            end
        end
        tests_run++;
        if (ch_data !== 4'b0010 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hunt_commit got=%b/%b want=0010/1", ch_data, out_valid);
        end
    endtask

    task automatic test_early_sof();
        logic [2:0] pat [7] = '{3'b111, 3'b101, 3'b101, 3'b110, 3'b100, 3'b101, 3'b100};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL early_beat%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (i == 3) begin
                tests_run++;
                if (sync_err !== 1'b1 || out_valid !== 1'b0 || ch_data !== 4'b0000) begin
                    failures++;
                    $display("FAIL early_sync_err got=%b/%b/%b want=1/0/0000", sync_err,
                             out_valid, ch_data);
                end
            end
        end
        tests_run++;
        if (ch_data !== 4'b0100 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL early_commit got=%b/%b want=0100/1", ch_data, out_valid);
        end
    endtask

    task automatic test_missing_sof();
        logic [2:0] pat [5] = '{3'b111, 3'b101, 3'b100, 3'b101, 3'b101};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL missing_beat%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0 || ch_data !== 4'b1011) begin
            failures++;
            $display("FAIL missing_sof got=%b/%b/%0d/%b want=1/0/0/1011", sync_err, locked,
                     slot, ch_data);
        end
    endtask

    task automatic test_gaps();
        logic [2:0] pat [8] = '{3'b111, 3'b000, 3'b100, 3'b000,
                                3'b101, 3'b000, 3'b101, 3'b000};
        int ov_cnt = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(pat[i][2], pat[i][1], pat[i][0]);
            if (out_valid) ov_cnt++;
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL gaps_cycle%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (ch_data !== 4'b1101 || ov_cnt != 1) begin
            failures++;
            $display("FAIL gaps_commit got=%b/%0d want=1101/1", ch_data, ov_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] pat [3] = '{3'b111, 3'b101, 3'b101};
        int ov_cnt = 0;
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(pat[i][2], pat[i][1], pat[i][0]);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b want=%b", obs_vec(), {VW{1'b0}});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (out_valid) ov_cnt++;
            tests_run++;
            if (obs_vec() !== exp_vec() || locked !== 1'b0) begin
                failures++;
                $display("FAIL async_after%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
        tests_run++;
        if (ov_cnt != 0) begin
            failures++;
            $display("FAIL async_no_ov got=%0d want=0", ov_cnt);
        end
    endtask

    task automatic test_random();
        logic v, s, d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 9) < 3);
            d = 1'($urandom);
            step(v, s, d);
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            tests_run++;
            if (out_valid === 1'b1 && sync_err === 1'b1) begin
                failures++;
                $display("FAIL random_excl%0d got=11 want=not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_hunt_discard();
        test_early_sof();
        test_missing_sof();
        test_gaps();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
